adc_acq_sequencer: RTL and testbench

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

---
 rtl/adc_acq_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer: paces ADC conversions into frames of samples, with
// optional inter-frame holdoff, bounded or free-running frame counts.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   start, abort          arm / stop request pulses
//   divider               conversion period in aclk cycles (>= 2)
//   frame_len             samples per frame (!= 0)
//   frame_count           frames per run, 0 = free-running
//   holdoff               idle cycles between frames
//   busy                  ADC busy, asynchronous to aclk
//   cnv                   conversion start pulse
//   sample, last          result-ready pulse, final sample of a frame
//   done                  normal run completion pulse
//   running               high whenever not idle
//   overrun               sticky: a due conversion was skipped
module adc_acq_sequencer #(
    parameter int DIV_WIDTH = 16,
    parameter int LEN_WIDTH = 16,
    parameter int FRM_WIDTH = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic [FRM_WIDTH-1:0] frame_count,
    input  logic [DIV_WIDTH-1:0] holdoff,
    input  logic                 busy,
    output logic                 cnv,
    output logic                 sample,
    output logic                 last,
    output logic                 done,
    output logic                 running,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLDOFF
    } state_t;

    state_t               state_q,   state_d;

    logic [DIV_WIDTH-1:0] div_q,     div_d;
    logic [LEN_WIDTH-1:0] len_q,     len_d;
    logic [FRM_WIDTH-1:0] fcnt_q,    fcnt_d;
    logic [DIV_WIDTH-1:0] hold_q,    hold_d;

    logic [DIV_WIDTH-1:0] pcnt_q,    pcnt_d;
    logic [DIV_WIDTH-1:0] hcnt_q,    hcnt_d;
    logic [LEN_WIDTH-1:0] cnv_cnt_q, cnv_cnt_d;
    logic [LEN_WIDTH-1:0] smp_cnt_q, smp_cnt_d;
    logic [FRM_WIDTH-1:0] frm_q,     frm_d;
    logic                 pending_q, pending_d;

    logic                 busy_s1_q, busy_s1_d;
    logic                 busy_s2_q, busy_s2_d;
    logic                 busy_s3_q, busy_s3_d;

    logic                 cnv_q,     cnv_d;
    logic                 sample_q,  sample_d;
    logic                 last_q,    last_d;
    logic                 done_q,    done_d;
    logic                 running_q, running_d;
    logic                 overrun_q, overrun_d;

    logic                 busy_fall;
    logic                 smp_hit;
    logic                 smp_last;
    logic                 accept;
    logic                 enter_run;
    logic                 frame_end;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        len_d     = len_q;
        fcnt_d    = fcnt_q;
        hold_d    = hold_q;
        pcnt_d    = pcnt_q;
        hcnt_d    = hcnt_q;
        cnv_cnt_d = cnv_cnt_q;
        smp_cnt_d = smp_cnt_q;
        frm_d     = frm_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        cnv_d     = 1'b0;
        sample_d  = 1'b0;
        last_d    = 1'b0;
        done_d    = 1'b0;

        busy_s1_d = busy;
        busy_s2_d = busy_s1_q;
        busy_s3_d = busy_s2_q;

        enter_run = 1'b0;
        frame_end = 1'b0;

        // s2 is the settled synchronizer output, s3 its previous value
        busy_fall = busy_s3_q & ~busy_s2_q;
        smp_hit   = busy_fall & pending_q
                  & ((state_q == RUN) || (state_q == DRAIN));
        smp_last  = smp_hit
                  & (smp_cnt_q == len_q - LEN_WIDTH'(1));
        accept    = (state_q == IDLE) & start & ~abort
                  & (divider >= DIV_WIDTH'(2))
                  & (frame_len != '0);

        if (smp_hit) begin
            sample_d  = 1'b1;
            last_d    = smp_last;
            pending_d = 1'b0;
            if (smp_last) begin
                smp_cnt_d = '0;
            end else begin
                smp_cnt_d = smp_cnt_q + LEN_WIDTH'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    div_d     = divider;
                    len_d     = frame_len;
                    fcnt_d    = frame_count;
                    hold_d    = holdoff;
                    overrun_d = 1'b0;
                    frm_d     = '0;
                    smp_cnt_d = '0;
                    hcnt_d    = '0;
                    pending_d = 1'b0;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                // the final cnv of a frame has gone out: stop pacing
                if (cnv_cnt_q == len_q) begin
                    if (smp_last) begin
                        frame_end = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (pcnt_q == div_q - DIV_WIDTH'(1)) begin
                    pcnt_d = '0;
                end else begin
                    pcnt_d = pcnt_q + DIV_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (smp_last) begin
                    frame_end = 1'b1;
                end
            end
            HOLDOFF: begin
                if (hcnt_q == hold_q - DIV_WIDTH'(1)) begin
                    enter_run = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + DIV_WIDTH'(1);
                end
            end
        endcase

        // frame counter wraps freely when the run is unbounded
        if (frame_end) begin
            frm_d = frm_q + FRM_WIDTH'(1);
            if ((fcnt_q != '0) && (frm_d == fcnt_q)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (hold_q == '0) begin
                enter_run = 1'b1;
            end else begin
                state_d = HOLDOFF;
                hcnt_d  = '0;
            end
        end

        if (enter_run) begin
            state_d   = RUN;
            pcnt_d    = '0;
            cnv_cnt_d = '0;
        end

        // a conversion is due on the first cycle of each period;
        // pending is checked after this cycle's sample may have cleared it
        if ((state_d == RUN) && (pcnt_d == '0)) begin
            if (pending_d) begin
                overrun_d = 1'b1;
            end else begin
                cnv_d     = 1'b1;
                pending_d = 1'b1;
                cnv_cnt_d = cnv_cnt_d + LEN_WIDTH'(1);
            end
        end

        if (abort) begin
            state_d   = IDLE;
            cnv_d     = 1'b0;
            sample_d  = 1'b0;
            last_d    = 1'b0;
            done_d    = 1'b0;
            pending_d = 1'b0;
            overrun_d = overrun_q;
        end

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            len_q     <= '0;
            fcnt_q    <= '0;
            hold_q    <= '0;
            pcnt_q    <= '0;
            hcnt_q    <= '0;
            cnv_cnt_q <= '0;
            smp_cnt_q <= '0;
            frm_q     <= '0;
            pending_q <= 1'b0;
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
            busy_s3_q <= 1'b0;
            cnv_q     <= 1'b0;
            sample_q  <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            len_q     <= len_d;
            fcnt_q    <= fcnt_d;
            hold_q    <= hold_d;
            pcnt_q    <= pcnt_d;
            hcnt_q    <= hcnt_d;
            cnv_cnt_q <= cnv_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            frm_q     <= frm_d;
            pending_q <= pending_d;
            busy_s1_q <= busy_s1_d;
            busy_s2_q <= busy_s2_d;
            busy_s3_q <= busy_s3_d;
            cnv_q     <= cnv_d;
            sample_q  <= sample_d;
            last_q    <= last_d;
            done_q    <= done_d;
            running_q <= running_d;
            overrun_q <= overrun_d;
        end
    end

    assign cnv     = cnv_q;
    assign sample  = sample_q;
    assign last    = last_q;
    assign done    = done_q;
    assign running = running_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb_adc_acq_sequencer: directed scenarios for adc_acq_sequencer with an
// ADC busy model and an event scoreboard keyed on cycle number.
module tb_adc_acq_sequencer;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int FW = 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic          abort;
    logic [DW-1:0] divider;
    logic [LW-1:0] frame_len;
    logic [FW-1:0] frame_count;
    logic [DW-1:0] holdoff;
    logic          busy = 1'b0;
    logic          cnv;
    logic          sample;
    logic          last;
    logic          done;
    logic          running;
    logic          overrun;

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int busy_def = 5;
    int busy_cnt = 0;

    int exp_cnv[$];
    int exp_smp[$];
    bit exp_last[$];
    int exp_done[$];
    int busy_lens[$];

    adc_acq_sequencer dut (
        .aclk        (aclk),
        .areset      (areset),
        .start       (start),
        .abort       (abort),
        .divider     (divider),
        .frame_len   (frame_len),
        .frame_count (frame_count),
        .holdoff     (holdoff),
        .busy        (busy),
        .cnv         (cnv),
        .sample      (sample),
        .last        (last),
        .done        (done),
        .running     (running),
        .overrun     (overrun)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ADC: busy rises with cnv and stays high for a per-conversion length
    always @(negedge aclk) begin
        if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) busy = 1'b0;
        end
        if (cnv) begin
            busy = 1'b1;
            if (busy_lens.size() > 0) busy_cnt = busy_lens.pop_front();
            else busy_cnt = busy_def;
        end
    end

    // scoreboard: every output event must match the head of its queue
    always @(negedge aclk) begin
        int  e;
        logic l;
        if (cnv) begin
            if (exp_cnv.size() > 0) e = exp_cnv.pop_front();
            else e = -1;
            chk("cnv_cycle", cyc, e);
        end
        if (sample) begin
            if (exp_smp.size() > 0) e = exp_smp.pop_front();
            else e = -1;
            chk("sample_cycle", cyc, e);
            if (exp_last.size() > 0) l = exp_last.pop_front();
            else l = 1'bx;
            chk("last_flag", 32'(last), 32'(l));
        end else if (last) begin
            chk("last_without_sample", 32'(last), 32'(sample));
        end
        if (done) begin
            if (exp_done.size() > 0) e = exp_done.pop_front();
            else e = -1;
            chk("done_cycle", cyc, e);
        end
    end

    // Reference timing: busy falls N cycles after cnv, two sync stages
    // plus edge detect plus the registered pulse put sample at cnv+N+3.
    task automatic push_run(input int s, input int div, input int len,
                            input int nfr, input int hold, input int bn,
                            input bit fin, output int lastc);
        int base;
        base  = s + 1;
        lastc = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < len; k++) begin
                exp_cnv.push_back(base + k * div);
                exp_smp.push_back(base + k * div + bn + 3);
                exp_last.push_back(k == len - 1);
            end
            lastc = base + (len - 1) * div + bn + 3;
            base  = lastc + hold;
        end
        if (fin) exp_done.push_back(lastc);
    endtask

    task automatic arm(input int d, input int l, input int fc,
                       input int h, output int s);
        @(negedge aclk);
        divider     = DW'(d);
        frame_len   = LW'(l);
        frame_count = FW'(fc);
        holdoff     = DW'(h);
        start       = 1'b1;
        s           = cyc;
    endtask

    task automatic drop_start();
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge aclk);
    endtask

    task automatic chk_empty(input string tag);
        chk(tag, 32'(exp_cnv.size() + exp_smp.size()
                     + exp_last.size() + exp_done.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int lc;
        areset      = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        divider     = '0;
        frame_len   = '0;
        frame_count = '0;
        holdoff     = '0;
        repeat (3) @(negedge aclk);
        chk("reset_outputs",
            32'({cnv, sample, last, done, running, overrun}), 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("idle_running", 32'(running), 0);

        // single frame; a start and config change mid-run are ignored
        busy_def = 5;
        arm(10, 4, 1, 0, s);
        push_run(s, 10, 4, 1, 0, 5, 1'b1, lc);
        drop_start();
        chk("sf_running", 32'(running), 1);
        wait_until(s + 5);
        divider     = DW'(3);
        frame_len   = LW'(7);
        frame_count = FW'(0);
        start       = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        wait_until(lc - 1);
        chk("sf_running_before_done", 32'(running), 1);
        wait_until(lc);
        chk("sf_running_at_done", 32'(running), 0);
        wait_until(lc + 3);
        chk_empty("sf_queues_empty");

        // three frames with 20-cycle holdoff
        arm(10, 2, 3, 20, s);
        push_run(s, 10, 2, 3, 20, 5, 1'b1, lc);
        drop_start();
        wait_until(s + 25);
        chk("mf_running_in_holdoff", 32'(running), 1);
        wait_until(lc + 3);
        chk_empty("mf_queues_empty");
        chk("mf_running_after", 32'(running), 0);

        // overrun: first conversion holds busy 10 cycles at divider 4
        busy_lens.push_back(10);
        busy_lens.push_back(2);
        arm(4, 2, 1, 0, s);
        exp_cnv.push_back(s + 1);
        exp_cnv.push_back(s + 17);
        exp_smp.push_back(s + 14);
        exp_last.push_back(1'b0);
        exp_smp.push_back(s + 22);
        exp_last.push_back(1'b1);
        exp_done.push_back(s + 22);
        drop_start();
        wait_until(s + 4);
        chk("ov_clear_before_skip", 32'(overrun), 0);
        wait_until(s + 5);
        chk("ov_set_on_skip", 32'(overrun), 1);
        wait_until(s + 25);
        chk("ov_sticky", 32'(overrun), 1);
        chk_empty("ov_queues_empty");
        busy_def = 1;
        arm(4, 2, 1, 0, s);
        push_run(s, 4, 2, 1, 0, 1, 1'b1, lc);
        drop_start();
        chk("ov_cleared_by_start", 32'(overrun), 0);
        wait_until(lc + 2);
        chk("ov_stays_clear", 32'(overrun), 0);
        chk_empty("ov2_queues_empty");

        // abort in DRAIN with a conversion still pending
        busy_def = 5;
        busy_lens.push_back(5);
        busy_lens.push_back(20);
        arm(10, 2, 1, 0, s);
        exp_cnv.push_back(s + 1);
        exp_cnv.push_back(s + 11);
        exp_smp.push_back(s + 9);
        exp_last.push_back(1'b0);
        drop_start();
        wait_until(s + 15);
        chk("ab_running_in_drain", 32'(running), 1);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        chk("ab_running_next", 32'(running), 0);
        wait_until(s + 45);
        chk_empty("ab_queues_empty");
        chk("ab_running_after", 32'(running), 0);

        // invalid configurations and start+abort together
        arm(1, 4, 1, 0, s);
        drop_start();
        wait_until(s + 6);
        chk("inv_div1", 32'(running), 0);
        arm(10, 0, 1, 0, s);
        drop_start();
        wait_until(s + 6);
        chk("inv_len0", 32'(running), 0);
        arm(10, 2, 1, 0, s);
        abort = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        abort = 1'b0;
        wait_until(s + 6);
        chk("start_abort_same", 32'(running), 0);
        chk_empty("inv_queues_empty");

        // free-running past frame counter wrap, then abort
        busy_def = 1;
        arm(2, 1, 0, 0, s);
        push_run(s, 2, 1, 260, 0, 1, 1'b0, lc);
        exp_cnv.push_back(lc);
        drop_start();
        wait_until(lc);
        chk("wrap_running", 32'(running), 1);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        chk("wrap_abort_running", 32'(running), 0);
        wait_until(lc + 10);
        chk_empty("wrap_queues_empty");

        // reset in RUN right after the first cnv
        busy_def = 5;
        arm(10, 4, 0, 0, s);
        exp_cnv.push_back(s + 1);
        drop_start();
        chk("rst_running_before", 32'(running), 1);
        #2;
        areset = 1'b1;
        #1;
        chk("rst_outputs_immediate",
            32'({cnv, sample, last, done, running, overrun}), 0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        s = cyc;
        wait_until(s + 40);
        chk("rst_no_resume", 32'(running), 0);
        chk_empty("rst_queues_empty");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
